// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg                                                          |
// | Shared defaults and helpers for the parametrised register file.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_scoreboard                                                   |
// | Per-register busy bits: set by issue, cleared by writeback.          |
// | Optional macro REGFILE_R0_ZERO_EN keeps busy[0] permanently clear.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_scoreboard #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_index,
    input  logic             we,
    input  logic [IDX_W-1:0] c_index,
    output logic [DEPTH-1:0] busy_vec
);

    logic             w_issue_en;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] r_busy;

`ifdef REGFILE_R0_ZERO_EN
    assign w_issue_en = issue_valid && (issue_index != '0);
`else
    assign w_issue_en = issue_valid;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_dec
        assign w_set[i] = w_issue_en && (issue_index == IDX_W'(i));
        assign w_clr[i] = we && (c_index == IDX_W'(i));
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign busy_vec = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_sb                                                           |
// | Parametrised register file: 2 async reads, 1 sync write, optional    |
// | write bypass and busy scoreboard. Macro REGFILE_R0_ZERO_EN makes     |
// | register 0 read as constant zero.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int BYPASS = 1,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IDX_W-1:0]       a_index,
    input  logic [IDX_W-1:0]       b_index,
    input  logic [IDX_W-1:0]       c_index,
    input  logic                   we,
    input  logic [WIDTH-1:0]       d_input,
    input  logic                   issue_valid,
    input  logic [IDX_W-1:0]       issue_index,
    output logic [WIDTH-1:0]       a_output,
    output logic [WIDTH-1:0]       b_output,
    output logic                   a_busy,
    output logic                   b_busy,
    output logic [DEPTH-1:0]       busy_vec,
    output logic [DEPTH*WIDTH-1:0] dbg_regs
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] w_view [DEPTH];
    logic             w_wr_en;
    logic [WIDTH-1:0] w_a_stored;
    logic [WIDTH-1:0] w_b_stored;

`ifdef REGFILE_R0_ZERO_EN
    assign w_wr_en = we && (c_index != '0);
`else
    assign w_wr_en = we;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[c_index] <= d_input;
        end
    end

    // w_view is what the outside world sees of each register.
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
`ifdef REGFILE_R0_ZERO_EN
        if (i == 0) begin : g_zero
            assign w_view[i] = '0;
        end else begin : g_reg
            assign w_view[i] = r_regs[i];
        end
`else
        assign w_view[i] = r_regs[i];
`endif
        assign dbg_regs[i*WIDTH +: WIDTH] = w_view[i];
    end

    assign w_a_stored = w_view[a_index];
    assign w_b_stored = w_view[b_index];

    if (BYPASS != 0) begin : g_bypass
        logic w_a_hit;
        logic w_b_hit;
        assign w_a_hit  = w_wr_en && !reset && (a_index == c_index);
        assign w_b_hit  = w_wr_en && !reset && (b_index == c_index);
        assign a_output = w_a_hit ? d_input : w_a_stored;
        assign b_output = w_b_hit ? d_input : w_b_stored;
    end else begin : g_no_bypass
        assign a_output = w_a_stored;
        assign b_output = w_b_stored;
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_index (issue_index),
        .we          (we),
        .c_index     (c_index),
        .busy_vec    (busy_vec)
    );

    // Hazard flags deliberately see only the registered busy state.
    assign a_busy = busy_vec[a_index];
    assign b_busy = busy_vec[b_index];

endmodule : regfile_sb
`default_nettype wire
